// File: rtl/riscv_pkg.sv
// Shared load/store encodings and the LSU bus FSM state type.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_format.sv
// Combinational lane logic: store replication/byte enables, fault detection,
// and load lane extraction with sign/zero extension.
module lsu_format
    import riscv_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        fault,
    output logic [31:0] ld_data
);

    logic [1:0] size;
    logic       illegal;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;

    // size: 0 byte, 1 halfword, 2 word
    always_comb begin
        size    = 2'd0;
        illegal = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB:   size = 2'd0;
                F3_SH:   size = 2'd1;
                F3_SW:   size = 2'd2;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: size = 2'd0;
                F3_LH, F3_LHU: size = 2'd1;
                F3_LW:         size = 2'd2;
                default:       illegal = 1'b1;
            endcase
        end
    end

    assign fault = illegal
                 | ((size == 2'd1) & addr_lo[0])
                 | ((size == 2'd2) & (|addr_lo));

    always_comb begin
        case (size)
            2'd0: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_if.sv
// M-stage load/store bus interface: single-outstanding req/ack transaction,
// stalls the pipeline until DONE, aborts with LsuErr after TIMEOUT_CYCLES.
module lsu_bus_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        StallMem,
    output logic        LsuFaultM,
    output logic        LsuErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    import riscv_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        access;
    logic        fmt_fault;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_ld_data;
    logic        term;

    assign access = MemWriteM | MemReadM;

    lsu_format u_format (
        .is_store  (MemWriteM),
        .funct3    (funct3M),
        .addr_lo   (Mem_WrAddr[1:0]),
        .st_data   (Mem_WrData),
        .ld_funct3 (ld_f3_q),
        .ld_off    (ld_off_q),
        .rdata     (bus_rdata),
        .be        (fmt_be),
        .wdata     (fmt_wdata),
        .fault     (fmt_fault),
        .ld_data   (fmt_ld_data)
    );

    // cnt_q counts BUSY cycles already elapsed, so this is the last allowed one
    assign term = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        ld_f3_d  = ld_f3_q;
        ld_off_d = ld_off_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !fmt_fault) begin
                    addr_d   = Mem_WrAddr[31:2];
                    we_d     = MemWriteM;
                    wdata_d  = fmt_wdata;
                    be_d     = fmt_be;
                    ld_f3_d  = funct3M;
                    ld_off_d = Mem_WrAddr[1:0];
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                // an ack on the terminal cycle still counts as a normal completion
                if (bus_ack) begin
                    if (!we_q) rdata_d = fmt_ld_data;
                    state_d = DONE;
                end else if (term) begin
                    if (!we_q) rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            ld_f3_q  <= '0;
            ld_off_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus_req   = (state_q == BUSY);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q, 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign ReadData  = rdata_q;
    assign LsuErr    = err_q;
    assign LsuFaultM = !reset && access && fmt_fault;
    assign StallMem  = !reset && ((state_q == BUSY) ||
                                  ((state_q == IDLE) && access && !fmt_fault));

endmodule

// File: doc/lsu_bus_if.md
# lsu_bus_if

Memory-stage load/store bus interface. Takes the M-stage access (address, store data, `funct3M`, read/write strobes) and runs a single-outstanding req/ack transaction on the data bus. It asserts a stall to the hazard unit until the access completes, and returns byte-lane-aligned, sign- or zero-extended `ReadData` for the M/W pipeline register. It sits directly downstream of the datapath's M-stage outputs and upstream of the memory/writeback register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of BUSY cycles to wait for `bus_ack` before aborting (must be ≥1).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemWriteM`  in  1  M-stage store strobe.
- `MemReadM`  in  1  M-stage load strobe.
- `funct3M`  in  3  access size/sign encoding.
- `Mem_WrAddr`  in  32  byte address.
- `Mem_WrData`  in  32  store data, right-justified.
- `ReadData`  out  32  formatted load result; registered.
- `StallMem`  out  1  freeze request to the hazard unit; combinational.
- `LsuFaultM`  out  1  misaligned access or illegal `funct3`; combinational.
- `LsuErr`  out  1  one-cycle pulse on bus timeout; registered.
- `bus_req`  out  1  transaction request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address, `{Mem_WrAddr[31:2],2'b00}`.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_be`  out  4  byte enables.
- `bus_ack`  in  1  transaction complete; `bus_rdata` is valid in the same cycle.
- `bus_rdata`  in  32  read word.

## Operation
- The block considers an access present when `MemWriteM | MemReadM`. If both are asserted, the write takes precedence.
- Legal `funct3` values: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw. Any other value sets `LsuFaultM`.
- Misaligned accesses: a halfword with `addr[0]=1`, or a word with `addr[1:0]≠0`, sets `LsuFaultM`.
- On a fault, no bus transaction is issued, `StallMem` stays 0, and `ReadData` holds its previous value.
- Store formatting:
  - sb: `be = 4'b0001<<addr[1:0]`, `wdata = {4{d[7:0]}}`.
  - sh: `be = 4'b0011<<{addr[1],1'b0}`, `wdata = {2{d[15:0]}}`.
  - sw: `be = 4'b1111`, `wdata = d`.
- Load formatting: select the byte or halfword lane from `bus_rdata` by `addr[1:0]`, then sign-extend (lb/lh) or zero-extend (lbu/lhu). lw passes the word through. Loads drive `bus_be` the same way as stores of the same size.
- FSM:
  - **IDLE**: in this state, `StallMem = access & ~LsuFaultM`. On a legal access, the block registers `bus_addr`/`bus_we`/`bus_wdata`/`bus_be` plus the size/sign/lane info, clears the timeout counter, and moves to BUSY.
  - **BUSY**: `bus_req=1`, `StallMem=1`, and the counter increments each cycle.
    - If `bus_ack` arrives, the block registers the formatted `bus_rdata` into `ReadData` (loads only; stores leave it unchanged) and moves to DONE.
    - Otherwise, if the counter reaches `TIMEOUT_CYCLES`, the block drives `ReadData=0` for loads, pulses `LsuErr`, and moves to DONE.
  - **DONE**: `bus_req=0` and `StallMem=0`, so the pipeline advances this cycle. Next state is IDLE unconditionally.
- `bus_ack` is ignored in IDLE and DONE.
- All bus outputs hold stable for the whole BUSY period.

## Timing
- Reset values: state IDLE, `bus_req/bus_we=0`, `bus_addr/bus_wdata=0`, `bus_be=0`, `ReadData=0`, `LsuErr=0`, counter 0. `StallMem` and `LsuFaultM` are forced to 0 while `reset=1`.
- Minimum occupancy of an access in M is 3 cycles (IDLE, BUSY with ack, DONE), i.e. 2 stall cycles. With an ack k cycles into BUSY, the access occupies k+2 cycles.
- Timeout: the block aborts after exactly `TIMEOUT_CYCLES` BUSY cycles without an ack.
- An ack arriving on the same cycle as the timeout terminal count wins: the access is treated as a normal completion and there is no `LsuErr`.
- `ReadData` is valid from the DONE cycle onward and holds until the next load completes. The M/W register captures it at the end of DONE.
- Reset mid-transaction: `bus_req` drops asynchronously and the state returns to IDLE. A late `bus_ack` afterwards is ignored.
- Back-to-back accesses: the next access enters M in the cycle after DONE, so there is one non-stalled cycle between transactions.

## Structure
- The shared package `riscv_pkg` holds the load/store `funct3` localparams and the `lsu_state_t` enum (IDLE, BUSY, DONE).
- One combinational sub-module, `lsu_format`, handles store lane replication, byte-enable generation, load extraction/extension, and fault detection. The FSM and timeout counter stay in `lsu_bus_if`.

## Test plan
- **Byte store:** sb to addr `0x1003` with data `0xAB`, ack on 1st BUSY cycle → `bus_addr=0x1000`, `be=1000`, `wdata=0xABABABAB`, `StallMem` high for exactly 2 cycles.
- **Load extension:** lb then lbu at `0x2001` with `bus_rdata=0x00F3_8000` → `ReadData=0xFFFFFF80`, then `0x00000080`. lh at `0x2002` with `bus_rdata=0x8001_0000` → `0xFFFF8001`.
- **Faults:** lw at `0x3002`, and `funct3=011` → `LsuFaultM=1`, `bus_req` never rises, `StallMem=0`, `ReadData` unchanged.
- **Timeout:** `TIMEOUT_CYCLES=4`, load with no ack → 4 BUSY cycles, then `LsuErr` 1-cycle pulse, `ReadData=0`. A second run with the ack on the 4th BUSY cycle completes normally with no `LsuErr`.
- **Reset mid-transaction:** reset asserted in the 2nd BUSY cycle → `bus_req` falls immediately, all outputs return to reset values. An ack pulsed after reset release causes no `ReadData` change.
- **Back-to-back:** sw followed by lw to the same word with acks delayed 3 cycles → correct occupancy of 5 cycles each, and the lw returns the word stored by the sw.
